// File: rtl/sad_chroma8x8.sv
// rtl/sad_chroma8x8.sv - chroma 8x8 per-mode SAD accumulator feeding the mode saver
//
// Purpose: accumulates the sum of absolute residues over one 8-row chroma block
// for the vertical, horizontal and DC predictions. The result is presented as
// three saturated SADs together with the macroblock number latched at start.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low (0 = reset)
//   start          begin a macroblock (honoured only when idle)
//   mbnumber_in    macroblock number, latched on an accepted start
//   row_valid      vrow/hrow/dcrow carry a row
//   row_ready      a row is accepted this cycle when row_valid is also high
//   vrow/hrow/dcrow  8 signed residues each, byte k = column k
//   sads           {dc, h, v}, each SAD_W bits, saturating
//   sads_valid     sads/mbnumber_out are valid
//   sads_ready     downstream takes sads this cycle
//   mbnumber_out   macroblock number belonging to sads
//   busy           block is accumulating or holding a result
module sad_chroma8x8 #(
  parameter int SAD_W = 8  // supported range 1..31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         mbnumber_in,
  input  logic               row_valid,
  output logic               row_ready,
  input  logic [63:0]        vrow,
  input  logic [63:0]        hrow,
  input  logic [63:0]        dcrow,
  output logic [3*SAD_W-1:0] sads,
  output logic               sads_valid,
  input  logic               sads_ready,
  output logic [8:0]         mbnumber_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  // 8 rows * 8 columns * 128 = 8192 fits in 14 bits without overflow.
  localparam int ACC_W = 14;
  localparam logic [31:0] SAD_MAX = 32'((64'd1 << SAD_W) - 64'd1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_v_q, acc_v_d;
  logic [ACC_W-1:0]   acc_h_q, acc_h_d;
  logic [ACC_W-1:0]   acc_dc_q, acc_dc_d;
  logic [8:0]         mb_q, mb_d;
  logic [3*SAD_W-1:0] sads_q, sads_d;
  logic               row_ready_q, row_ready_d;
  logic               sads_valid_q, sads_valid_d;
  logic               busy_q, busy_d;

  // |x| of an 8-bit two's complement value as 8-bit unsigned: |-128| = 128.
  function automatic logic [10:0] row_abs_sum(input logic [63:0] row);
    logic [10:0] sum;
    logic [7:0]  b;
    logic [7:0]  mag;
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      b   = row[8*k +: 8];
      mag = b[7] ? 8'(~b + 8'd1) : b;
      sum = sum + {3'd0, mag};
    end
    return sum;
  endfunction

  function automatic logic [SAD_W-1:0] sat(input logic [ACC_W-1:0] a);
    logic [31:0] w;
    w = {{(32-ACC_W){1'b0}}, a};
    if (w > SAD_MAX) begin
      return {SAD_W{1'b1}};
    end
    return w[SAD_W-1:0];
  endfunction

  logic row_accept;
  assign row_accept = row_ready_q && row_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_v_d      = acc_v_q;
    acc_h_d      = acc_h_q;
    acc_dc_d     = acc_dc_q;
    mb_d         = mb_q;
    sads_d       = sads_q;
    row_ready_d  = row_ready_q;
    sads_valid_d = sads_valid_q;
    busy_d       = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_v_d     = '0;
          acc_h_d     = '0;
          acc_dc_d    = '0;
          cnt_d       = '0;
          mb_d        = mbnumber_in;
          state_d     = S_ACCUM;
          row_ready_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_ACCUM: begin
        if (row_accept) begin
          acc_v_d  = acc_v_q  + {3'd0, row_abs_sum(vrow)};
          acc_h_d  = acc_h_q  + {3'd0, row_abs_sum(hrow)};
          acc_dc_d = acc_dc_q + {3'd0, row_abs_sum(dcrow)};
          cnt_d    = 3'(cnt_q + 3'd1);
          if (cnt_q == 3'd7) begin
            // Capture the final sums into the output register on the last row.
            state_d      = S_OUT;
            row_ready_d  = 1'b0;
            sads_valid_d = 1'b1;
            sads_d       = {sat(acc_dc_d), sat(acc_h_d), sat(acc_v_d)};
          end
        end
      end
      S_OUT: begin
        if (sads_ready) begin
          state_d      = S_IDLE;
          sads_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
      end
      default: begin
        state_d      = S_IDLE;
        row_ready_d  = 1'b0;
        sads_valid_d = 1'b0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_v_q      <= '0;
      acc_h_q      <= '0;
      acc_dc_q     <= '0;
      mb_q         <= '0;
      sads_q       <= '0;
      row_ready_q  <= 1'b0;
      sads_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_v_q      <= acc_v_d;
      acc_h_q      <= acc_h_d;
      acc_dc_q     <= acc_dc_d;
      mb_q         <= mb_d;
      sads_q       <= sads_d;
      row_ready_q  <= row_ready_d;
      sads_valid_q <= sads_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign row_ready    = row_ready_q;
  assign sads         = sads_q;
  assign sads_valid   = sads_valid_q;
  assign mbnumber_out = mb_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sad_chroma8x8.sv
// tb/tb_sad_chroma8x8.sv - self-checking bench for sad_chroma8x8 (SAD_W=8 and SAD_W=14)
module tb_sad_chroma8x8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [8:0]  mbnumber_in;
  logic        row_valid;
  logic [63:0] vrow, hrow, dcrow;
  logic        sads_ready;

  logic        row_ready, sads_valid, busy;
  logic [23:0] sads;
  logic [8:0]  mbnumber_out;

  logic        row_ready14, sads_valid14, busy14;
  logic [41:0] sads14;
  logic [8:0]  mbnumber_out14;

  int checks;
  int failures;

  localparam logic [63:0] GARB = 64'h8080_8080_8080_8080;

  sad_chroma8x8 #(.SAD_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber_in(mbnumber_in),
    .row_valid(row_valid), .row_ready(row_ready),
    .vrow(vrow), .hrow(hrow), .dcrow(dcrow),
    .sads(sads), .sads_valid(sads_valid), .sads_ready(sads_ready),
    .mbnumber_out(mbnumber_out), .busy(busy)
  );

  sad_chroma8x8 #(.SAD_W(14)) u_dut14 (
    .clk(clk), .reset(reset), .start(start), .mbnumber_in(mbnumber_in),
    .row_valid(row_valid), .row_ready(row_ready14),
    .vrow(vrow), .hrow(hrow), .dcrow(dcrow),
    .sads(sads14), .sads_valid(sads_valid14), .sads_ready(sads_ready),
    .mbnumber_out(mbnumber_out14), .busy(busy14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  mb;
    logic [63:0] v, h, dc, dc0;  // dc0 is the DC row used for row 0
    logic [7:0]  e_v, e_h, e_dc;
    logic [13:0] e14_v, e14_h, e14_dc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sads(input vec_t t);
    chk("sad_v", 32'(sads[7:0]), 32'(t.e_v));
    chk("sad_h", 32'(sads[15:8]), 32'(t.e_h));
    chk("sad_dc", 32'(sads[23:16]), 32'(t.e_dc));
    chk("sad14_v", 32'(sads14[13:0]), 32'(t.e14_v));
    chk("sad14_h", 32'(sads14[27:14]), 32'(t.e14_h));
    chk("sad14_dc", 32'(sads14[41:28]), 32'(t.e14_dc));
    chk("mbnumber_out", 32'(mbnumber_out), 32'(t.mb));
  endtask

  task automatic begin_mb(input logic [8:0] mb);
    start       = 1'b1;
    mbnumber_in = mb;
    tick();
    start       = 1'b0;
    mbnumber_in = 9'd0;
    chk("busy_in_accum", 32'(busy), 32'd1);
    chk("row_ready_in_accum", 32'(row_ready), 32'd1);
  endtask

  // Feeds 8 rows; with gaps, idle cycles carry garbage that must not be summed.
  task automatic feed_rows(input vec_t t, input bit gaps);
    int n;
    for (int r = 0; r < 8; r++) begin
      if (gaps) begin
        n = $urandom_range(0, 3);
        repeat (n) begin
          row_valid = 1'b0;
          vrow = GARB; hrow = GARB; dcrow = GARB;
          tick();
        end
      end
      vrow  = t.v;
      hrow  = t.h;
      dcrow = (r == 0) ? t.dc0 : t.dc;
      if (r == 7) chk("valid_before_last_row", 32'(sads_valid), 32'd0);
      row_valid = 1'b1;
      tick();
    end
    row_valid = 1'b0;
    vrow = GARB; hrow = GARB; dcrow = GARB;
  endtask

  task automatic handshake_to_idle();
    sads_ready = 1'b1;
    tick();
    sads_ready = 1'b0;
    chk("busy_after_handshake", 32'(busy), 32'd0);
    chk("valid_after_handshake", 32'(sads_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vec_t t;
    checks   = 0;
    failures = 0;

    // mb 5: all zero
    vecs[0] = '{9'd5, 64'h0, 64'h0, 64'h0, 64'h0, 8'd0, 8'd0, 8'd0, 14'd0, 14'd0, 14'd0};
    // v all +1, h all -1, dc only row0 byte0 = 2
    vecs[1] = '{9'd12, 64'h0101_0101_0101_0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h2,
                8'd64, 8'd64, 8'd2, 14'd64, 14'd64, 14'd2};
    // all -128: 8192 per mode, saturates at 8 bits
    vecs[2] = '{9'd300, GARB, GARB, GARB, GARB,
                8'd255, 8'd255, 8'd255, 14'd8192, 14'd8192, 14'd8192};
    // v 127s: 8128; h 16s: 1024; dc byte0 = 3: 24
    vecs[3] = '{9'd7, 64'h7F7F_7F7F_7F7F_7F7F, 64'h1010_1010_1010_1010, 64'h3, 64'h3,
                8'd255, 8'd255, 8'd24, 14'd8128, 14'd1024, 14'd24};
    // v two -16s: 256 -> 255; h all -2: 128; dc 38 + 7*31 = 255 exactly
    vecs[4] = '{9'd511, 64'hF0F0_0000_0000_0000, 64'hFEFE_FEFE_FEFE_FEFE, 64'h1F, 64'h26,
                8'd255, 8'd128, 8'd255, 14'd256, 14'd128, 14'd255};

    reset = 1'b0; start = 1'b0; mbnumber_in = 9'd0; row_valid = 1'b0;
    vrow = 64'h0; hrow = 64'h0; dcrow = 64'h0; sads_ready = 1'b0;
    #12;
    chk("rst_row_ready", 32'(row_ready), 32'd0);
    chk("rst_sads_valid", 32'(sads_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sads", 32'(sads), 32'd0);
    chk("rst_mbnumber_out", 32'(mbnumber_out), 32'd0);
    reset = 1'b1;
    tick();

    // Table: back-to-back rows, sads_valid exactly at cycle 9
    for (int i = 0; i < 5; i++) begin
      begin_mb(vecs[i].mb);
      feed_rows(vecs[i], 1'b0);
      chk("valid_at_cycle9", 32'(sads_valid), 32'd1);
      chk("row_ready_in_out", 32'(row_ready), 32'd0);
      check_sads(vecs[i]);
      handshake_to_idle();
    end

    // Gapped rows, then downstream stalls 5 cycles while rows keep arriving
    t = vecs[1];
    t.mb = 9'd200;
    begin_mb(t.mb);
    feed_rows(t, 1'b1);
    chk("valid_after_gapped_rows", 32'(sads_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      row_valid = 1'b1;
      vrow = GARB; hrow = GARB; dcrow = GARB;
      tick();
      chk("stall_valid", 32'(sads_valid), 32'd1);
      chk("stall_row_ready", 32'(row_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      check_sads(t);
    end
    row_valid = 1'b0;
    handshake_to_idle();
    chk("idle_row_ready", 32'(row_ready), 32'd0);

    // Asynchronous reset mid-accumulation, then a clean restart
    begin_mb(9'd77);
    vrow = GARB; hrow = GARB; dcrow = GARB;
    row_valid = 1'b1;
    repeat (4) tick();
    row_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_row_ready", 32'(row_ready), 32'd0);
    chk("async_rst_sads_valid", 32'(sads_valid), 32'd0);
    chk("async_rst_sads", 32'(sads), 32'd0);
    chk("async_rst_mbnumber_out", 32'(mbnumber_out), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    t = vecs[1];
    t.mb = 9'd88;
    begin_mb(t.mb);
    feed_rows(t, 1'b0);
    chk("restart_valid", 32'(sads_valid), 32'd1);
    check_sads(t);
    handshake_to_idle();

    // start with another mb number during ACCUM, OUT and the handshake cycle
    t = vecs[3];
    t.mb = 9'd37;
    begin_mb(t.mb);
    start = 1'b1;
    mbnumber_in = 9'd99;
    feed_rows(t, 1'b0);
    chk("start_ignored_valid", 32'(sads_valid), 32'd1);
    check_sads(t);
    repeat (2) tick();
    check_sads(t);
    sads_ready = 1'b1;
    tick();
    start = 1'b0;
    sads_ready = 1'b0;
    chk("start_in_handshake_busy", 32'(busy), 32'd0);
    tick();
    chk("start_in_handshake_still_idle", 32'(busy), 32'd0);
    chk("mb_not_relatched", 32'(mbnumber_out), 32'd37);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
